pc_branch_unit: RTL and testbench

Program-counter and branch-resolution unit for the Simple RISC Machine datapath. It sits directly downstream of the control FSM and consumes the FSM's `reset_pc`, `load_pc`, `load_bpc` and `loads` strobes. It holds the PC and the Z/N/V status flags, and resolves conditional branches (B, BEQ, BNE, BLT, BLE) in a fixed three-edge sequence. It drives the instruction-fetch address and reports branch outcome back to the FSM.

---
 rtl/rm_pkg.sv | 23 ++
 rtl/pc_branch_unit_if.sv | 27 ++
 rtl/pc_branch_unit_branch_cond.sv | 23 ++
 rtl/pc_branch_unit.sv | 85 ++++++++
 tb/tb_pc_branch_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/rm_pkg.sv
// Shared types for the Simple RISC Machine branch path: condition codes,
// branch FSM states and bit positions inside the {N, V, Z} status word.
package rm_pkg;

    typedef enum logic [2:0] {
        COND_B   = 3'b000,
        COND_BEQ = 3'b001,
        COND_BNE = 3'b010,
        COND_BLT = 3'b011,
        COND_BLE = 3'b100
    } cond_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } br_state_t;

    localparam int ST_N = 2;
    localparam int ST_V = 1;
    localparam int ST_Z = 0;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Strobe/status bundle between the control FSM (master) and the PC/branch unit (slave).
interface pc_branch_unit_if #(
    parameter int PC_W = 9
);
    logic            reset_pc;
    logic            load_pc;
    logic            load_bpc;
    logic [2:0]      cond;
    logic [15:0]     sximm8;
    logic            loads;
    logic [2:0]      status_in;
    logic [PC_W-1:0] pc;
    logic [2:0]      status;
    logic            br_busy;
    logic            br_done;
    logic            br_taken;

    modport master (
        output reset_pc, load_pc, load_bpc, cond, sximm8, loads, status_in,
        input  pc, status, br_busy, br_done, br_taken
    );

    modport slave (
        input  reset_pc, load_pc, load_bpc, cond, sximm8, loads, status_in,
        output pc, status, br_busy, br_done, br_taken
    );
endinterface

// File: rtl/pc_branch_unit_branch_cond.sv
// Combinational branch-condition decoder: (cond, N, V, Z) -> taken.
// Codes 101-111 are reserved and never taken.
module branch_cond
    import rm_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       n,
    input  logic       v,
    input  logic       z,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_B:   taken = 1'b1;
            COND_BEQ: taken = z;
            COND_BNE: taken = ~z;
            COND_BLT: taken = n ^ v;
            COND_BLE: taken = (n ^ v) | z;
            default:  taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, status flags and a three-edge branch resolver
// (IDLE -> EVAL -> COMMIT) driven by the control FSM strobes.
module pc_branch_unit
    import rm_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_branch_unit_if.slave       bus
);
    br_state_t       state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [2:0]      status_reg;
    logic [2:0]      cond_reg;
    logic [PC_W-1:0] offset_reg;
    logic [2:0]      snap_reg;
    logic [PC_W-1:0] target_reg;
    logic            taken_reg;
    logic            taken_next;
    logic            unused_offset_hi;

    // Offset bits above PC_W cannot influence a wrapped PC_W-bit target.
    assign unused_offset_hi = ^bus.sximm8[15:PC_W];

    branch_cond u_branch_cond (
        .cond  (cond_reg),
        .n     (snap_reg[ST_N]),
        .v     (snap_reg[ST_V]),
        .z     (snap_reg[ST_Z]),
        .taken (taken_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            status_reg <= '0;
            cond_reg   <= '0;
            offset_reg <= '0;
            snap_reg   <= '0;
            target_reg <= '0;
            taken_reg  <= 1'b0;
        end else begin
            if (bus.loads)
                status_reg <= bus.status_in;

            // reset_pc aborts any in-flight branch without touching br_taken.
            if (bus.reset_pc) begin
                pc_reg    <= '0;
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.load_pc)
                            pc_reg <= pc_reg + PC_W'(1);
                        if (bus.load_bpc) begin
                            cond_reg   <= bus.cond;
                            offset_reg <= bus.sximm8[PC_W-1:0];
                            snap_reg   <= status_reg;
                            state_reg  <= EVAL;
                        end
                    end
                    EVAL: begin
                        taken_reg  <= taken_next;
                        target_reg <= pc_reg + offset_reg;
                        state_reg  <= COMMIT;
                    end
                    COMMIT: begin
                        if (taken_reg)
                            pc_reg <= target_reg;
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.pc       = pc_reg;
    assign bus.status   = status_reg;
    assign bus.br_busy  = (state_reg != IDLE);
    assign bus.br_done  = (state_reg == COMMIT);
    assign bus.br_taken = taken_reg;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomized + directed bench for pc_branch_unit against a cycle-level
// behavioural model of the PC, flags and the three-edge branch timing.
module tb_pc_branch_unit;
    localparam int PC_W = 9;
    localparam int PC_MOD = 1 << PC_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_branch_unit_if #(.PC_W(PC_W)) bus ();

    pc_branch_unit #(.PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Model: phase counts edges since an accepted request (0 = no branch).
    int         m_pc;
    logic [2:0] m_status;
    int         m_phase;
    logic [2:0] m_cond;
    logic [15:0] m_off;
    logic [2:0] m_snap;
    logic       m_taken;
    int         m_target;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] nvz);
        logic n, v, z;
        n = nvz[2]; v = nvz[1]; z = nvz[0];
        if (c == 3'd0) return 1'b1;
        if (c == 3'd1) return z;
        if (c == 3'd2) return !z;
        if (c == 3'd3) return n != v;
        if (c == 3'd4) return (n != v) || z;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_status = 3'b000; m_phase = 0; m_taken = 1'b0;
        m_cond = 3'd0; m_off = 16'd0; m_snap = 3'd0; m_target = 0;
    endtask

    task automatic model_edge(input logic rpc, input logic lpc, input logic lbpc,
                              input logic [2:0] c, input logic [15:0] imm,
                              input logic ld, input logic [2:0] st);
        logic [2:0] old_status;
        int t;
        old_status = m_status;
        if (rpc) begin
            m_pc = 0;
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (lpc) m_pc = (m_pc + 1) % PC_MOD;
            if (lbpc) begin
                m_cond = c; m_off = imm; m_snap = old_status; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_taken = cond_holds(m_cond, m_snap);
            t = m_pc + int'($signed(m_off));
            m_target = ((t % PC_MOD) + PC_MOD) % PC_MOD;
            m_phase = 2;
        end else begin
            if (m_taken) m_pc = m_target;
            m_phase = 0;
        end
        if (ld) m_status = st;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".pc"},     32'(bus.pc),       32'(m_pc));
        check({ctx, ".status"}, 32'(bus.status),   32'(m_status));
        check({ctx, ".busy"},   32'(bus.br_busy),  32'(m_phase != 0));
        check({ctx, ".done"},   32'(bus.br_done),  32'(m_phase == 2));
        check({ctx, ".taken"},  32'(bus.br_taken), 32'(m_taken));
    endtask

    // Called at a negedge: drive, clock, update model, compare, return at next negedge.
    task automatic tick(input string ctx, input logic rpc, input logic lpc, input logic lbpc,
                        input logic [2:0] c, input logic [15:0] imm,
                        input logic ld, input logic [2:0] st);
        bus.reset_pc = rpc; bus.load_pc = lpc; bus.load_bpc = lbpc;
        bus.cond = c; bus.sximm8 = imm; bus.loads = ld; bus.status_in = st;
        @(posedge clk);
        model_edge(rpc, lpc, lbpc, c, imm, ld, st);
        #1;
        check_all(ctx);
        @(negedge clk);
        bus.reset_pc = 0; bus.load_pc = 0; bus.load_bpc = 0; bus.loads = 0;
    endtask

    task automatic idle(input string ctx);
        tick(ctx, 0, 0, 0, 3'd0, 16'd0, 0, 3'd0);
    endtask

    initial begin
        bus.reset_pc = 0; bus.load_pc = 0; bus.load_bpc = 0; bus.cond = 0;
        bus.sximm8 = 0; bus.loads = 0; bus.status_in = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Three increments then BEQ with Z=1, offset -2
        tick("clr", 1, 0, 0, 3'd0, 16'd0, 1, 3'b001);
        for (int i = 0; i < 3; i++) tick("inc", 0, 1, 0, 3'd0, 16'd0, 0, 3'd0);
        tick("beq_e0", 0, 0, 1, 3'd1, 16'hFFFE, 0, 3'd0);
        idle("beq_e1");
        check("beq_done_after_e1", 32'(bus.br_done), 32'd1);
        idle("beq_e2");
        check("beq_pc", 32'(bus.pc), 32'h001);
        check("beq_taken", 32'(bus.br_taken), 32'd1);

        // BNE with Z=1 from pc=0x010: not taken
        tick("clr2", 1, 0, 0, 3'd0, 16'd0, 0, 3'd0);
        tick("b16", 0, 0, 1, 3'd0, 16'd16, 0, 3'd0);
        idle("b16_e1"); idle("b16_e2");
        tick("bne_e0", 0, 0, 1, 3'd2, 16'd5, 0, 3'd0);
        idle("bne_e1"); idle("bne_e2");
        check("bne_pc", 32'(bus.pc), 32'h010);
        check("bne_taken", 32'(bus.br_taken), 32'd0);
        check("bne_done_once", 32'(bus.br_done), 32'd0);

        // BLT/BLE sweep from pc=0x1FF with offset +1 (wraps to 0 when taken)
        for (int c = 3; c <= 4; c++) begin
            for (int f = 0; f < 8; f++) begin
                logic holds;
                logic [2:0] nvz;
                nvz = 3'(f);
                holds = (c == 3) ? (nvz[2] != nvz[1]) : ((nvz[2] != nvz[1]) || nvz[0]);
                tick("sw_clr", 1, 0, 0, 3'd0, 16'd0, 1, nvz);
                tick("sw_b", 0, 0, 1, 3'd0, 16'hFFFF, 0, 3'd0);
                idle("sw_b1"); idle("sw_b2");
                tick("sw_e0", 0, 0, 1, 3'(c), 16'd1, 0, 3'd0);
                idle("sw_e1"); idle("sw_e2");
                check("sweep_pc", 32'(bus.pc), holds ? 32'h000 : 32'h1FF);
            end
        end

        // Status change, increment and second request while in EVAL
        tick("snap_clr", 1, 0, 0, 3'd0, 16'd0, 1, 3'b001);
        tick("snap_e0", 0, 0, 1, 3'd1, 16'd3, 0, 3'd0);
        tick("snap_e1", 0, 1, 1, 3'd0, 16'd100, 1, 3'b000);
        idle("snap_e2");
        check("snap_pc", 32'(bus.pc), 32'h003);
        check("snap_taken", 32'(bus.br_taken), 32'd1);
        check("snap_status", 32'(bus.status), 32'd0);
        check("snap_busy_after", 32'(bus.br_busy), 32'd0);

        // reset_pc during EVAL aborts the branch
        tick("ab_clr", 1, 0, 0, 3'd0, 16'd0, 0, 3'd0);
        tick("ab_e0", 0, 0, 1, 3'd0, 16'd7, 0, 3'd0);
        tick("ab_rpc", 1, 0, 0, 3'd0, 16'd0, 0, 3'd0);
        check("abort_busy", 32'(bus.br_busy), 32'd0);
        idle("ab_idle");
        check("abort_no_done", 32'(bus.br_done), 32'd0);
        tick("ab_new", 0, 0, 1, 3'd0, 16'd4, 0, 3'd0);
        idle("ab_new1"); idle("ab_new2");
        check("abort_new_pc", 32'(bus.pc), 32'h004);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 16'($urandom), ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
        end

        // Async reset mid-run with pc=0x1A and a branch in flight
        tick("ar_clr", 1, 0, 0, 3'd0, 16'd0, 1, 3'b111);
        tick("ar_b", 0, 0, 1, 3'd0, 16'h001A, 0, 3'd0);
        idle("ar_b1"); idle("ar_b2");
        check("ar_pc_pre", 32'(bus.pc), 32'h01A);
        tick("ar_req", 0, 0, 1, 3'd0, 16'd9, 0, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_pc", 32'(bus.pc), 32'h000);
        check("async_status", 32'(bus.status), 32'd0);
        check("async_busy", 32'(bus.br_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("ar_hold");
        tick("ar_after", 0, 1, 0, 3'd0, 16'd0, 0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
